// File: rtl/mul_sched_pkg.sv
// mul_sched_pkg: shared constants and the tag type for the multiplier issue
// scheduler (mul_sched). Imported by the arbiter and the top.
//   OP_W    default operand width
//   PRODT_W product width (2*OP_W)
//   MAX_REQ largest supported requester count
//   IDX_W   width of a requester index
//   tag_t   in-flight tag {v, idx} carried alongside the multiplier latency
package mul_sched_pkg;

  localparam int unsigned OP_W    = 16;
  localparam int unsigned PRODT_W = 2 * OP_W;
  localparam int unsigned MAX_REQ = 8;
  localparam int unsigned IDX_W   = 3;

  typedef struct packed {
    logic             v;
    logic [IDX_W-1:0] idx;
  } tag_t;

endpackage

// File: rtl/mul_sched_if.sv
// mul_sched_if: bundles the requester handshake, the multiplier operand and
// product buses and the response/status outputs of mul_sched.
//   req_valid/req_ready  per-requester handshake (req_ready one-hot)
//   req_mlier/req_mcand  packed operands, requester i at [i*OP_W +: OP_W]
//   mul_mlier/mul_mcand  registered operands towards the shared multiplier
//   mul_prodt            registered product back from the multiplier
//   rsp_valid/rsp_prodt  one-hot response pulse and its product
//   busy                 any operation in flight
// Modports: slave = scheduler view, master = clients + multiplier view.
interface mul_sched_if #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned OP_W  = 16
);

  logic [N_REQ-1:0]      req_valid;
  logic [N_REQ-1:0]      req_ready;
  logic [N_REQ*OP_W-1:0] req_mlier;
  logic [N_REQ*OP_W-1:0] req_mcand;
  logic [OP_W-1:0]       mul_mlier;
  logic [OP_W-1:0]       mul_mcand;
  logic [2*OP_W-1:0]     mul_prodt;
  logic [N_REQ-1:0]      rsp_valid;
  logic [2*OP_W-1:0]     rsp_prodt;
  logic                  busy;

  modport slave (
    input  req_valid, req_mlier, req_mcand, mul_prodt,
    output req_ready, mul_mlier, mul_mcand, rsp_valid, rsp_prodt, busy
  );

  modport master (
    output req_valid, req_mlier, req_mcand, mul_prodt,
    input  req_ready, mul_mlier, mul_mcand, rsp_valid, rsp_prodt, busy
  );

endinterface

// File: rtl/mul_sched_arb.sv
// mul_sched_arb: combinational grant for the shared multiplier.
// Build option MUL_SCHED_RR_EN: round-robin with a pointer register that moves
// to one past the last winner; otherwise fixed priority (lowest index wins) and
// no state at all.
//   clock    clock (round-robin build only)
//   reset_n  asynchronous active-low reset; forces the grant to zero
//   req_i    request vector
//   gnt_o    one-hot grant
//   idx_o    index of the granted requester
//   any_o    a grant is being issued
module mul_sched_arb
  import mul_sched_pkg::*;
#(
  parameter int unsigned N_REQ = 4
) (
`ifdef MUL_SCHED_RR_EN
  input  logic             clock,
`endif
  input  logic             reset_n,
  input  logic [N_REQ-1:0] req_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  logic             found;
  logic [IDX_W-1:0] win;

`ifdef MUL_SCHED_RR_EN
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [N_REQ-1:0] rot;
  int unsigned      pos;

  // Rotate so the pointer position lands at bit 0, then take the first set
  // bit and map its offset back to an absolute index.
  always_comb begin
    rot   = (req_i >> ptr_q) | (req_i << (N_REQ - 32'(ptr_q)));
    found = 1'b0;
    win   = '0;
    pos   = 0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (!found && rot[k]) begin
        found = 1'b1;
        pos   = 32'(ptr_q) + k;
        if (pos >= N_REQ) pos = pos - N_REQ;
        win   = IDX_W'(pos);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (any_o) ptr_d = (idx_o == IDX_W'(N_REQ - 1)) ? '0 : idx_o + 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) ptr_q <= '0;
    else          ptr_q <= ptr_d;
  end
`else
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (!found && req_i[i]) begin
        found = 1'b1;
        win   = IDX_W'(i);
      end
    end
  end
`endif

  always_comb begin
    any_o = found & reset_n;
    idx_o = win;
    gnt_o = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      gnt_o[i] = any_o && (win == IDX_W'(i));
    end
  end

endmodule

// File: rtl/mul_sched.sv
// mul_sched: issue scheduler sharing one registered multiplier among N_REQ
// requesters. Arbitrates every cycle, registers the winner's operands onto the
// multiplier bus, carries the winner's index through a tag pipeline matched to
// MUL_LAT and returns the product as a one-cycle one-hot response pulse.
// Build option MUL_SCHED_RR_EN selects round-robin arbitration (default:
// fixed priority, lowest index first).
//   clock    rising-edge clock
//   reset_n  asynchronous active-low reset, discards in-flight operations
//   bus      mul_sched_if.slave (handshake, operand/product buses, status)
// Parameters: N_REQ (2..8), OP_W, MUL_LAT (1..4).
module mul_sched
  import mul_sched_pkg::*;
#(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned OP_W    = 16,
  parameter int unsigned MUL_LAT = 1
) (
  input logic        clock,
  input logic        reset_n,
  mul_sched_if.slave bus
);

  localparam int unsigned PW = 2 * OP_W;

  logic [N_REQ-1:0] gnt;
  logic [IDX_W-1:0] gnt_idx;
  logic             gnt_any;

  logic [OP_W-1:0]  mlier_q, mlier_d;
  logic [OP_W-1:0]  mcand_q, mcand_d;
  tag_t             tag_q [0:MUL_LAT];
  tag_t             tag_d;
  logic [N_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [PW-1:0]    rsp_prodt_q, rsp_prodt_d;
  logic             busy_w;

  mul_sched_arb #(
    .N_REQ(N_REQ)
  ) u_arb (
`ifdef MUL_SCHED_RR_EN
    .clock  (clock),
`endif
    .reset_n(reset_n),
    .req_i  (bus.req_valid),
    .gnt_o  (gnt),
    .idx_o  (gnt_idx),
    .any_o  (gnt_any)
  );

  // A grant is only issued to a valid requester, so any grant is an accept.
  always_comb begin
    mlier_d = mlier_q;
    mcand_d = mcand_q;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (gnt[i]) begin
        mlier_d = bus.req_mlier[i*OP_W +: OP_W];
        mcand_d = bus.req_mcand[i*OP_W +: OP_W];
      end
    end
    tag_d.v   = gnt_any;
    tag_d.idx = gnt_any ? gnt_idx : '0;
  end

  always_comb begin
    rsp_valid_d = '0;
    rsp_prodt_d = rsp_prodt_q;
    if (tag_q[MUL_LAT].v) begin
      rsp_prodt_d = bus.mul_prodt;
      for (int unsigned i = 0; i < N_REQ; i++) begin
        rsp_valid_d[i] = (tag_q[MUL_LAT].idx == IDX_W'(i));
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mlier_q     <= '0;
      mcand_q     <= '0;
      rsp_valid_q <= '0;
      rsp_prodt_q <= '0;
      for (int unsigned s = 0; s <= MUL_LAT; s++) tag_q[s] <= '0;
    end else begin
      mlier_q     <= mlier_d;
      mcand_q     <= mcand_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_prodt_q <= rsp_prodt_d;
      tag_q[0]    <= tag_d;
      for (int unsigned s = 1; s <= MUL_LAT; s++) tag_q[s] <= tag_q[s-1];
    end
  end

  always_comb begin
    busy_w = |rsp_valid_q;
    for (int unsigned s = 0; s <= MUL_LAT; s++) busy_w = busy_w | tag_q[s].v;
  end

  assign bus.req_ready = gnt;
  assign bus.mul_mlier = mlier_q;
  assign bus.mul_mcand = mcand_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_prodt = rsp_prodt_q;
  assign bus.busy      = busy_w;

endmodule

// File: tb/tb_mul_sched.sv
// tb_mul_sched: directed bench for mul_sched with a queue scoreboard. The
// stimulus process checks grants and pushes the hand-computed response (index,
// product, due cycle); an independent monitor pops and checks responses.
// Expected grant orders follow MUL_SCHED_RR_EN when it is defined.
module tb_mul_sched;

  localparam int unsigned N = 4;
  localparam int unsigned W = 16;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  int   cyc     = 0;

  mul_sched_if #(.N_REQ(N), .OP_W(W)) bus ();

  mul_sched #(
    .N_REQ  (N),
    .OP_W   (W),
    .MUL_LAT(1)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  // One-stage registered multiplier standing in for the real array.
  always @(posedge clock) bus.mul_prodt <= 32'(bus.mul_mlier) * 32'(bus.mul_mcand);

  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int unsigned idx;
    logic [31:0] prod;
    int          due;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Monitor: every cycle the response bus must match the scoreboard head if
  // one is due now, and be quiet otherwise.
  always @(negedge clock) begin
    exp_t e;
    if (sbq.size() > 0 && sbq[0].due == cyc) begin
      e = sbq.pop_front();
      chk("rsp_valid", 32'(bus.rsp_valid), 32'(1) << e.idx);
      chk("rsp_prodt", bus.rsp_prodt, e.prod);
    end else begin
      chk("rsp_quiet", 32'(bus.rsp_valid), 32'd0);
    end
  end

  task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b);
    bus.req_mlier[i*W +: W] = a;
    bus.req_mcand[i*W +: W] = b;
  endtask

  // Called just after a rising edge with inputs applied; checks the grant
  // mid-cycle, records the expected response and returns after the next edge.
  task automatic issue(input string nm, input int exp_idx, input logic [31:0] exp_prod);
    @(negedge clock);
    chk(nm, 32'(bus.req_ready), (exp_idx < 0) ? 32'd0 : (32'(1) << exp_idx));
    if (exp_idx >= 0) sbq.push_back('{idx: exp_idx, prod: exp_prod, due: cyc + 3});
    @(posedge clock); #1;
  endtask

  task automatic idle(input int n, input string nm);
    repeat (n) begin
      @(negedge clock);
      chk({nm, "_ready"}, 32'(bus.req_ready), 32'd0);
      chk({nm, "_busy"}, 32'(bus.busy), 32'd0);
      @(posedge clock); #1;
    end
  endtask

  task automatic drain();
    repeat (4) begin
      @(posedge clock); #1;
    end
  endtask

  int          all_idx[5];
  int          tie_idx;
  logic [31:0] prod_tab[4];

  initial begin
    prod_tab = '{32'h200, 32'h303, 32'h408, 32'h50F};
`ifdef MUL_SCHED_RR_EN
    all_idx = '{0, 1, 2, 3, 0};
    tie_idx = 2;
`else
    all_idx = '{0, 0, 0, 0, 0};
    tie_idx = 1;
`endif

    // Reset: requests present but nothing granted, all outputs zero.
    bus.req_valid = '1;
    bus.req_mlier = '0;
    bus.req_mcand = '0;
    @(negedge clock);
    chk("rst_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_mlier", 32'(bus.mul_mlier), 32'd0);
    chk("rst_mcand", 32'(bus.mul_mcand), 32'd0);
    chk("rst_prodt", bus.rsp_prodt, 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    @(posedge clock); #1;
    reset_n       = 1'b1;
    bus.req_valid = '0;

    // Single request on requester 1, granted in the first cycle after reset.
    set_req(1, 16'h0003, 16'h0005);
    bus.req_valid = 4'b0010;
    issue("single_gnt", 1, 32'h0000000F);
    bus.req_valid = '0;
    @(negedge clock);
    chk("single_busy", 32'(bus.busy), 32'd1);
    @(posedge clock); #1;
    drain();

    // Operand extremes, back to back.
    set_req(0, 16'hFFFF, 16'hFFFF);
    set_req(3, 16'h0000, 16'h1234);
    bus.req_valid = 4'b0001;
    issue("ext_max_gnt", 0, 32'hFFFE0001);
    bus.req_valid = 4'b1000;
    issue("ext_zero_gnt", 3, 32'h00000000);
    bus.req_valid = '0;
    drain();

    // All four requesting for five cycles.
    set_req(0, 16'h0002, 16'h0100);
    set_req(1, 16'h0003, 16'h0101);
    set_req(2, 16'h0004, 16'h0102);
    set_req(3, 16'h0005, 16'h0103);
    bus.req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) issue("all_gnt", all_idx[k], prod_tab[all_idx[k]]);
    bus.req_valid = '0;
    drain();

    // Pointer wrap: req 2 alone, then req 1 alone, then both (tie-break
    // exposes where the pointer ended up).
    set_req(2, 16'h0007, 16'h0009);
    set_req(1, 16'h0010, 16'h0010);
    bus.req_valid = 4'b0100;
    issue("wrap_r2", 2, 32'h0000003F);
    bus.req_valid = 4'b0010;
    issue("wrap_r1", 1, 32'h00000100);
    bus.req_valid = 4'b0110;
    issue("wrap_tie", tie_idx, (tie_idx == 2) ? 32'h0000003F : 32'h00000100);
    bus.req_valid = '0;
    drain();

    // Reset while an operation is in flight: it must never respond.
    bus.req_valid = 4'b0100;
    issue("rstmid_gnt", 2, 32'h0000003F);
    void'(sbq.pop_back());
    bus.req_valid = 4'b1111;
    reset_n       = 1'b0;
    @(negedge clock);
    chk("rstmid_ready", 32'(bus.req_ready), 32'd0);
    chk("rstmid_mlier", 32'(bus.mul_mlier), 32'd0);
    chk("rstmid_mcand", 32'(bus.mul_mcand), 32'd0);
    chk("rstmid_prodt", bus.rsp_prodt, 32'd0);
    chk("rstmid_busy", 32'(bus.busy), 32'd0);
    @(posedge clock); #1;
    reset_n       = 1'b1;
    bus.req_valid = '0;
    idle(6, "rstmid_after");

    // Idle stretch.
    idle(10, "idle");

    chk("sb_empty", 32'(sbq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mul_sched.md
# mul_sched

Issue scheduler sharing one registered array multiplier (16x16 -> 32, fixed latency, no output handshake) among N_REQ requesters. Each cycle it arbitrates among requesters with pending operand pairs, drives the winner's operands into the multiplier, tracks the in-flight requester index through a latency-matched tag pipeline, and returns each product to its originating requester as a one-cycle response pulse. It sits between the multiplier instance and the client blocks; the multiplier's own `valid` output is ignored.

## Interface
- `N_REQ`, 4, number of requesters (2..8)
- `OP_W`, 16, operand width; product width is 2*OP_W
- `MUL_LAT`, 1, clock edges from multiplier operand input to registered product output (1..4)

- `clock`  in  1  sole clock, rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `req_valid`  in  N_REQ  requester i has an operand pair pending
- `req_ready`  out  N_REQ  one-hot grant; transfer when `req_valid[i] & req_ready[i]`
- `req_mlier`  in  N_REQ*OP_W  multiplier operand, requester i at bits [i*OP_W +: OP_W]
- `req_mcand`  in  N_REQ*OP_W  multiplicand operand, same packing
- `mul_mlier`  out  OP_W  operand to multiplier, registered
- `mul_mcand`  out  OP_W  operand to multiplier, registered
- `mul_prodt`  in  2*OP_W  registered product from multiplier
- `rsp_valid`  out  N_REQ  one-hot, one-cycle pulse per completed product
- `rsp_prodt`  out  2*OP_W  product for the requester flagged in `rsp_valid`
- `busy`  out  1  any operation in flight

## Operation
- Grant: `req_ready` is combinational from `req_valid` and the arbiter pointer; exactly one bit set if any `req_valid` set, else all zero. Never set while `reset_n` low.
- Accept: on the edge ending a cycle with `req_valid[i] & req_ready[i]`, register `req_mlier[i]`/`req_mcand[i]` into `mul_mlier`/`mul_mcand` and push tag {v=1, idx=i} into stage 0 of the tag pipeline; otherwise push {v=0}; `mul_*` hold last value.
- Tag pipeline: MUL_LAT+1 stages of {v, idx}, shifting every cycle unconditionally. At last stage with v=1: register `mul_prodt` into `rsp_prodt`, set `rsp_valid` = one-hot(idx) for one cycle. With v=0: `rsp_valid` = 0, `rsp_prodt` holds.
- Throughput: one accept per cycle; no backpressure on responses (clients must sink every pulse).
- Requests are not dropped: a requester keeps `req_valid` and operands stable until granted.
- `busy` = OR of all tag-stage v bits and `rsp_valid` non-zero.
- Arithmetic is unsigned; product width exact, no truncation.
- Reset (asynchronous, any time): `mul_mlier`=0, `mul_mcand`=0, all tag stages v=0 idx=0, `rsp_valid`=0, `rsp_prodt`=0, arbiter pointer=0, `busy`=0. In-flight operations are discarded; no response ever issues for them after reset release.

## Timing
- Request accepted in cycle c -> operands on `mul_*` in cycle c+1 -> product on `mul_prodt` in cycle c+1+MUL_LAT -> `rsp_valid` pulse in cycle c+2+MUL_LAT. Default latency: 3 cycles after accept cycle.
- Back-to-back accepts produce back-to-back responses in the same order.
- First grant possible in the first cycle after `reset_n` rises.

## Configuration
- `MUL_SCHED_RR_EN` defined: round-robin. Pointer p (reset 0); search starts at p, wraps modulo N_REQ; after an accept of index i, p <= (i+1) mod N_REQ; no accept -> p holds.
- Not defined: fixed priority, lowest index wins; pointer register absent.

## Structure
- Package `mul_sched_pkg`: OP_W, PRODT_W = 2*OP_W, MAX_REQ = 8, IDX_W = 3, typedef for tag {v, idx}.
- One sub-module `mul_sched_arb`: combinational grant from request vector and pointer, plus pointer register under `MUL_SCHED_RR_EN`.

## Test plan
- Single request: req 1 valid with mlier=16'h0003, mcand=16'h0005 in cycle 0 -> `req_ready`=4'b0010 cycle 0; `rsp_valid`=4'b0010, `rsp_prodt`=32'h0000000F in cycle 3.
- Extremes: 16'hFFFF x 16'hFFFF on req 0 -> `rsp_prodt`=32'hFFFE0001; 0 x 16'h1234 -> 0.
- All four valid continuously, RR_EN defined -> grants 0,1,2,3,0 on consecutive cycles; responses in same order cycles 3..7; undefined -> grant stays 4'b0001 every cycle.
- Pointer wrap: RR_EN, p=3, only req 1 valid -> req 1 granted, p becomes 2.
- Reset mid-flight: accept on req 2 in cycle 0, `reset_n` low in cycle 1, released cycle 2 -> `rsp_valid` stays 0 through cycle 6; all outputs zero during reset.
- Idle: no `req_valid` for 10 cycles -> `req_ready`=0, `busy`=0, `rsp_valid`=0.
